// File: rtl/branch_predictor.sv
// branch_predictor
//   Direct-mapped branch target buffer. Each entry holds a valid bit, a tag,
//   a target and a 2-bit saturating direction counter. The IF stage looks up
//   a PC combinationally. The EX stage writes back one resolved branch per
//   cycle. Two saturating counters track resolved branches and mispredictions.
//
// Ports
//   clk_i               clock; all state updates on the rising edge
//   rst_i               synchronous active-high reset
//   lookup_pc_i         PC being fetched
//   hit_o               lookup PC matches a valid entry
//   predict_taken_o     hit and counter MSB set
//   next_pc_o           predicted target, or lookup_pc_i + 4
//   update_valid_i      a branch resolved this cycle
//   update_pc_i         PC of the resolved branch
//   update_taken_i      actual outcome
//   update_target_i     actual taken target
//   update_mispredict_i IF-time prediction was wrong
//   branch_cnt_o        resolved branches (saturating)
//   mispredict_cnt_o    mispredictions (saturating)
module branch_predictor #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 16,
  parameter logic [1:0]  CTR_INIT = 2'b01
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            hit_o,
  output logic            predict_taken_o,
  output logic [XLEN-1:0] next_pc_o,
  input  logic            update_valid_i,
  input  logic [XLEN-1:0] update_pc_i,
  input  logic            update_taken_i,
  input  logic [XLEN-1:0] update_target_i,
  input  logic            update_mispredict_i,
  output logic [31:0]     branch_cnt_o,
  output logic [31:0]     mispredict_cnt_o
);

  localparam int unsigned IDX  = $clog2(ENTRIES);
  localparam int unsigned TAGW = XLEN - IDX - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAGW-1:0]    tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

  logic [IDX-1:0]  l_idx, u_idx;
  logic [TAGW-1:0] l_tag, u_tag;
  logic            u_hit;
  logic [1:0]      ctr_d;

  // Lookup path: purely combinational on registered table state, so a
  // same-cycle update is never bypassed into the lookup.
  always_comb begin
    l_idx           = lookup_pc_i[IDX+1:2];
    l_tag           = lookup_pc_i[XLEN-1:IDX+2];
    hit_o           = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    predict_taken_o = hit_o && ctr_q[l_idx][1];
    next_pc_o       = predict_taken_o ? target_q[l_idx] : lookup_pc_i + XLEN'(4);
  end

  always_comb begin
    u_idx = update_pc_i[IDX+1:2];
    u_tag = update_pc_i[XLEN-1:IDX+2];
    u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    ctr_d = ctr_q[u_idx];
    if (update_taken_i) begin
      if (ctr_q[u_idx] != 2'b11) ctr_d = ctr_q[u_idx] + 2'b01;
    end else begin
      if (ctr_q[u_idx] != 2'b00) ctr_d = ctr_q[u_idx] - 2'b01;
    end
  end

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + 32'd1;
    if (update_mispredict_i && (mispredict_cnt_q != '1))
      mispredict_cnt_d = mispredict_cnt_q + 32'd1;
  end

  // Tag and target are left unreset: valid gates every use of them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q          <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
    end else if (update_valid_i) begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      if (u_hit) begin
        ctr_q[u_idx] <= ctr_d;
        if (update_taken_i) target_q[u_idx] <= update_target_i;
      end else if (update_taken_i) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= update_target_i;
        ctr_q[u_idx]    <= 2'b10;
      end
    end
  end

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a behavioural BTB model supplies
// the expected lookup and counter values, which are queued when stimulus is
// driven and compared when the DUT output is sampled on the falling edge.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        hit, ptaken;
  logic [31:0] next_pc;
  logic        upd_v, upd_t, upd_m;
  logic [31:0] upd_pc, upd_tgt;
  logic [31:0] bcnt, mcnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(32), .ENTRIES(16), .CTR_INIT(2'b01)) dut (
    .clk_i(clk), .rst_i(rst),
    .lookup_pc_i(lookup_pc), .hit_o(hit), .predict_taken_o(ptaken), .next_pc_o(next_pc),
    .update_valid_i(upd_v), .update_pc_i(upd_pc), .update_taken_i(upd_t),
    .update_target_i(upd_tgt), .update_mispredict_i(upd_m),
    .branch_cnt_o(bcnt), .mispredict_cnt_o(mcnt)
  );

  // Reference model
  bit        m_valid [16];
  bit [25:0] m_tag   [16];
  bit [31:0] m_tgt   [16];
  bit [1:0]  m_ctr   [16];
  bit [31:0] m_bcnt, m_mcnt;

  typedef struct {
    logic        hit;
    logic        tk;
    logic [31:0] npc;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;
  exp_t sb[$];

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic bit m_hit(input bit [31:0] pc);
    return m_valid[pc[5:2]] && (m_tag[pc[5:2]] == pc[31:6]);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 2'b01;
    end
    m_bcnt = 0;
    m_mcnt = 0;
  endtask

  task automatic m_update(input bit [31:0] pc, input bit t, input bit [31:0] tgt, input bit mis);
    bit [3:0] i;
    i = pc[5:2];
    if (m_hit(pc)) begin
      if (t) begin
        if (m_ctr[i] != 2'b11) m_ctr[i]++;
        m_tgt[i] = tgt;
      end else if (m_ctr[i] != 2'b00) m_ctr[i]--;
    end else if (t) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = pc[31:6];
      m_tgt[i]   = tgt;
      m_ctr[i]   = 2'b10;
    end
    if (m_bcnt != 32'hFFFFFFFF) m_bcnt++;
    if (mis && m_mcnt != 32'hFFFFFFFF) m_mcnt++;
  endtask

  // One clock of stimulus: inputs driven just after a rising edge, expectation
  // (pre-update table state) queued, output checked on the falling edge, then
  // the model advances across the next rising edge.
  task automatic cycle(input bit [31:0] lpc, input bit v, input bit [31:0] upc,
                       input bit t, input bit [31:0] tgt, input bit mis, input bit r);
    exp_t e, o;
    bit   h;
    h     = m_hit(lpc);
    e.hit = h;
    e.tk  = h && m_ctr[lpc[5:2]][1];
    e.npc = e.tk ? m_tgt[lpc[5:2]] : lpc + 32'd4;
    e.bc  = m_bcnt;
    e.mc  = m_mcnt;
    sb.push_back(e);
    rst = r; lookup_pc = lpc; upd_v = v; upd_pc = upc; upd_t = t; upd_tgt = tgt; upd_m = mis;
    @(negedge clk);
    o = sb.pop_front();
    check_eq("hit", {31'b0, hit}, {31'b0, o.hit});
    check_eq("predict_taken", {31'b0, ptaken}, {31'b0, o.tk});
    check_eq("next_pc", next_pc, o.npc);
    check_eq("branch_cnt", bcnt, o.bc);
    check_eq("mispredict_cnt", mcnt, o.mc);
    @(posedge clk);
    #1;
    if (r) m_reset();
    else if (v) m_update(upc, t, tgt, mis);
  endtask

  task automatic look(input bit [31:0] pc);
    cycle(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic upd(input bit [31:0] lpc, input bit [31:0] pc, input bit t,
                     input bit [31:0] tgt, input bit mis);
    cycle(lpc, 1'b1, pc, t, tgt, mis, 1'b0);
  endtask

  initial begin
    rst = 1'b1; lookup_pc = '0; upd_v = 1'b0; upd_pc = '0; upd_t = 1'b0;
    upd_tgt = '0; upd_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();

    // Reset state, plus fixed values
    look(32'h100);
    check_eq("reset_next_pc_const", next_pc, 32'h104);

    // Allocate, then hit with prediction
    upd(32'h0, 32'h100, 1'b1, 32'h40, 1'b0);
    look(32'h100);
    check_eq("alloc_next_pc_const", next_pc, 32'h40);
    check_eq("alloc_bcnt_const", bcnt, 32'd1);

    // Counter walk 10->01->00->00->01
    for (int k = 0; k < 3; k++) begin
      upd(32'h0, 32'h100, 1'b0, 32'h0, 1'b0);
      look(32'h100);
    end
    upd(32'h0, 32'h100, 1'b1, 32'h44, 1'b0);
    look(32'h100);
    check_eq("walk_taken_const", {31'b0, ptaken}, 32'd0);
    check_eq("walk_hit_const", {31'b0, hit}, 32'd1);

    // Alias eviction
    upd(32'h0, 32'h100, 1'b1, 32'h40, 1'b0);
    upd(32'h0, 32'h140, 1'b1, 32'h80, 1'b0);
    look(32'h100);
    look(32'h140);
    check_eq("alias_next_pc_const", next_pc, 32'h80);

    // Same-cycle lookup and update: no bypass
    upd(32'h200, 32'h200, 1'b1, 32'h300, 1'b0);
    look(32'h200);

    // update_* ignored without update_valid_i
    cycle(32'h200, 1'b0, 32'h400, 1'b1, 32'h500, 1'b1, 1'b0);
    look(32'h400);

    // Counters, then reset discards history
    cycle(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    upd(32'h0, 32'h100, 1'b1, 32'h40, 1'b1);
    upd(32'h0, 32'h100, 1'b1, 32'h40, 1'b0);
    upd(32'h0, 32'h100, 1'b0, 32'h40, 1'b1);
    upd(32'h0, 32'h100, 1'b1, 32'h40, 1'b1);
    upd(32'h0, 32'h100, 1'b1, 32'h40, 1'b0);
    look(32'h100);
    check_eq("cnt5_const", bcnt, 32'd5);
    check_eq("mis3_const", mcnt, 32'd3);
    // reset concurrent with an update: reset wins
    cycle(32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 1'b1, 1'b1);
    look(32'h100);
    check_eq("post_reset_hit_const", {31'b0, hit}, 32'd0);

    // Random traffic over a small PC space to exercise aliasing and saturation
    for (int k = 0; k < 300; k++) begin
      bit [31:0] lp, up;
      lp = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom), 2'b00};
      up = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom), 2'b00};
      cycle(lp, 1'($urandom), up, 1'($urandom), $urandom & 32'hFFFC, 1'($urandom), 1'b0);
    end

    // Branch counter saturation
    @(negedge clk);
    force dut.branch_cnt_q = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    release dut.branch_cnt_q;
    m_bcnt = 32'hFFFFFFFF;
    upd(32'h0, 32'h100, 1'b1, 32'h40, 1'b0);
    look(32'h100);
    check_eq("sat_const", bcnt, 32'hFFFFFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
